// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and limits for the multi-slot alarm controller.
// Provides the FSM state type, BCD digit/time types, the BCD time limits and
// a helper that validates a 24-hour BCD time.
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZED = 2'd2
   } alarm_state_t;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t ms_hr;
      bcd_t ls_hr;
      bcd_t ms_min;
      bcd_t ls_min;
   } alarm_time_t;

   localparam bcd_t MAX_MS_HR       = 4'd2;
   localparam bcd_t MAX_LS_HR_AT_20 = 4'd3;
   localparam bcd_t MAX_MS_MIN      = 4'd5;
   localparam bcd_t MAX_LS_MIN      = 4'd9;

   // True when t is a legal 00:00..23:59 time.
   function automatic logic time_valid(input alarm_time_t t);
      return (t.ms_hr <= MAX_MS_HR) &&
             !((t.ms_hr == MAX_MS_HR) && (t.ls_hr > MAX_LS_HR_AT_20)) &&
             (t.ms_min <= MAX_MS_MIN) &&
             (t.ls_min <= MAX_LS_MIN);
   endfunction

endpackage

// File: rtl/multi_alarm_ctrl_if.sv
// multi_alarm_ctrl_if: slot load bus and slot display read bus.
// master = keyreg / lcd_driver side (drives new alarm digits, load strobe,
// slot selects); slave = alarm controller (returns load_error, slot time).
interface multi_alarm_ctrl_if #(
   parameter int SLOT_W = 2
);
   logic [3:0]        new_alarm_ms_hr;
   logic [3:0]        new_alarm_ls_hr;
   logic [3:0]        new_alarm_ms_min;
   logic [3:0]        new_alarm_ls_min;
   logic              load_new_a;
   logic [SLOT_W-1:0] load_slot;
   logic              load_error;

   logic [SLOT_W-1:0] disp_slot;
   logic [3:0]        alarm_time_ms_hr;
   logic [3:0]        alarm_time_ls_hr;
   logic [3:0]        alarm_time_ms_min;
   logic [3:0]        alarm_time_ls_min;

   modport master (
      output new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
      output load_new_a, load_slot, disp_slot,
      input  load_error,
      input  alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min
   );

   modport slave (
      input  new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
      input  load_new_a, load_slot, disp_slot,
      output load_error,
      output alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min
   );
endinterface

// File: rtl/alarm_slot_bank.sv
// alarm_slot_bank: NUM_ALARMS BCD alarm slots with validated writes,
// per-slot compare against the current time and a combinational display read.
// Ports: clock/reset (sync, active-high); bus = load + display interface
// (slave); cur_time = current BCD time; alarm_en = per-slot arm; match = armed
// slots equal to the current time (combinational).
module alarm_slot_bank
   import alarm_pkg::*;
#(
   parameter int NUM_ALARMS = 4,
   parameter int SLOT_W     = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   multi_alarm_ctrl_if.slave     bus,
   input  alarm_time_t           cur_time,
   input  logic [NUM_ALARMS-1:0] alarm_en,
   output logic [NUM_ALARMS-1:0] match
);

   alarm_time_t           slot_q [NUM_ALARMS];
   logic                  load_error_q;
   alarm_time_t           new_t;
   logic [NUM_ALARMS-1:0] slot_hit;
   logic                  load_ok;
   alarm_time_t           rd_t;

   assign new_t = '{ms_hr:  bus.new_alarm_ms_hr,  ls_hr:  bus.new_alarm_ls_hr,
                    ms_min: bus.new_alarm_ms_min, ls_min: bus.new_alarm_ls_min};

   // One-hot decode of load_slot; an out-of-range slot decodes to all zeros.
   always_comb begin
      slot_hit = '0;
      for (int i = 0; i < NUM_ALARMS; i++)
         slot_hit[i] = (bus.load_slot == SLOT_W'(i));
   end

   assign load_ok = time_valid(new_t) && (|slot_hit);

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_ALARMS; i++)
            slot_q[i] <= '0;
         load_error_q <= 1'b0;
      end else begin
         load_error_q <= bus.load_new_a && !load_ok;
         for (int i = 0; i < NUM_ALARMS; i++)
            if (bus.load_new_a && load_ok && slot_hit[i])
               slot_q[i] <= new_t;
      end
   end

   assign bus.load_error = load_error_q;

   always_comb begin
      for (int i = 0; i < NUM_ALARMS; i++)
         match[i] = alarm_en[i] && (slot_q[i] == cur_time);
   end

   // Display read; an out-of-range disp_slot reads 00:00.
   always_comb begin
      rd_t = '0;
      for (int i = 0; i < NUM_ALARMS; i++)
         if (bus.disp_slot == SLOT_W'(i))
            rd_t = slot_q[i];
   end

   assign bus.alarm_time_ms_hr  = rd_t.ms_hr;
   assign bus.alarm_time_ls_hr  = rd_t.ls_hr;
   assign bus.alarm_time_ms_min = rd_t.ms_min;
   assign bus.alarm_time_ls_min = rd_t.ls_min;

endmodule

// File: rtl/multi_alarm_ctrl.sv
// multi_alarm_ctrl: NUM_ALARMS alarm slots plus ring/snooze FSM with auto-timeout.
// Ports: clock/reset (sync, active-high); one_second/one_minute timebase
// pulses; current_time_* BCD time; alarm_en arm bits; stop/snooze buttons;
// bus = load + display interface (slave); alarm_sound/snoozing/active_slot status.
// Optional macro MULTI_ALARM_SNOOZE_LIMIT_EN: after MAX_SNOOZE snoozes in one
// event, a further snooze press stops the alarm.
module multi_alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int NUM_ALARMS = 4,
   parameter int SLOT_W     = 2,
   parameter int SNOOZE_MIN = 5,
   parameter int RING_SEC   = 60,
   parameter int MAX_SNOOZE = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  one_second,
   input  logic                  one_minute,
   input  logic [3:0]            current_time_ms_hr,
   input  logic [3:0]            current_time_ls_hr,
   input  logic [3:0]            current_time_ms_min,
   input  logic [3:0]            current_time_ls_min,
   input  logic [NUM_ALARMS-1:0] alarm_en,
   input  logic                  stop_button,
   input  logic                  snooze_button,
   multi_alarm_ctrl_if.slave     bus,
   output logic                  alarm_sound,
   output logic [SLOT_W-1:0]     active_slot,
   output logic                  snoozing
);

   localparam logic [7:0] RING_C   = 8'(RING_SEC);
   localparam logic [3:0] SNOOZE_C = 4'(SNOOZE_MIN);
   localparam logic [3:0] MAX_SN_C = 4'(MAX_SNOOZE);

   alarm_time_t           cur_t;
   logic [NUM_ALARMS-1:0] match;
   logic [NUM_ALARMS-1:0] match_q;
   logic [NUM_ALARMS-1:0] trig_q;
   logic [SLOT_W-1:0]     win_slot;
   logic                  act_en;
   logic                  stop_req;
   logic                  snooze_as_stop;

   alarm_state_t          state_q;
   logic [7:0]            ring_cnt_q;
   logic [3:0]            snooze_cnt_q;
   logic [3:0]            snooze_used_q;
   logic [SLOT_W-1:0]     active_slot_q;
   logic                  alarm_sound_q;
   logic                  snoozing_q;

   assign cur_t = '{ms_hr:  current_time_ms_hr,  ls_hr:  current_time_ls_hr,
                    ms_min: current_time_ms_min, ls_min: current_time_ls_min};

   alarm_slot_bank #(
      .NUM_ALARMS (NUM_ALARMS),
      .SLOT_W     (SLOT_W)
   ) u_bank (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus),
      .cur_time (cur_t),
      .alarm_en (alarm_en),
      .match    (match)
   );

   // Rising-edge trigger is registered so the FSM acts one clock after the
   // edge: time change -> match_q/trig_q -> state, two clocks in total.
   always_ff @(posedge clock) begin
      if (reset) begin
         match_q <= '0;
         trig_q  <= '0;
      end else begin
         match_q <= match;
         trig_q  <= match & ~match_q;
      end
   end

   // Lowest triggering index wins.
   always_comb begin
      win_slot = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--)
         if (trig_q[i])
            win_slot = SLOT_W'(i);
   end

   always_comb begin
      act_en = 1'b0;
      for (int i = 0; i < NUM_ALARMS; i++)
         if (active_slot_q == SLOT_W'(i))
            act_en = alarm_en[i];
   end

   // Disarming the active slot ends the event exactly like a stop press.
   assign stop_req = stop_button || !act_en;

`ifdef MULTI_ALARM_SNOOZE_LIMIT_EN
   assign snooze_as_stop = snooze_button && (snooze_used_q == MAX_SN_C);
`else
   assign snooze_as_stop = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         ring_cnt_q    <= '0;
         snooze_cnt_q  <= '0;
         snooze_used_q <= '0;
         active_slot_q <= '0;
         alarm_sound_q <= 1'b0;
         snoozing_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|trig_q) begin
                  state_q       <= RINGING;
                  active_slot_q <= win_slot;
                  ring_cnt_q    <= RING_C;
                  snooze_used_q <= '0;
                  alarm_sound_q <= 1'b1;
                  snoozing_q    <= 1'b0;
               end
            end
            RINGING: begin
               if (stop_req || snooze_as_stop) begin
                  state_q       <= IDLE;
                  alarm_sound_q <= 1'b0;
               end else if (snooze_button) begin
                  state_q       <= SNOOZED;
                  snooze_cnt_q  <= SNOOZE_C;
                  alarm_sound_q <= 1'b0;
                  snoozing_q    <= 1'b1;
                  // Saturating: only the comparison against MAX_SNOOZE matters.
                  if (snooze_used_q != MAX_SN_C)
                     snooze_used_q <= snooze_used_q + 4'd1;
               end else if (one_second) begin
                  if (ring_cnt_q <= 8'd1) begin
                     state_q       <= IDLE;
                     ring_cnt_q    <= '0;
                     alarm_sound_q <= 1'b0;
                  end else begin
                     ring_cnt_q <= ring_cnt_q - 8'd1;
                  end
               end
            end
            SNOOZED: begin
               if (stop_req) begin
                  state_q    <= IDLE;
                  snoozing_q <= 1'b0;
               end else if (one_minute) begin
                  if (snooze_cnt_q <= 4'd1) begin
                     state_q       <= RINGING;
                     snooze_cnt_q  <= '0;
                     ring_cnt_q    <= RING_C;
                     alarm_sound_q <= 1'b1;
                     snoozing_q    <= 1'b0;
                  end else begin
                     snooze_cnt_q <= snooze_cnt_q - 4'd1;
                  end
               end
            end
            default: begin
               state_q       <= IDLE;
               alarm_sound_q <= 1'b0;
               snoozing_q    <= 1'b0;
            end
         endcase
      end
   end

   assign alarm_sound = alarm_sound_q;
   assign snoozing    = snoozing_q;
   assign active_slot = active_slot_q;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// tb_multi_alarm_ctrl: directed scenarios plus randomized traffic checked
// against a behavioural model that keeps alarm times as minutes-of-day and
// the event as a mode plus seconds/minutes remaining.
module tb_multi_alarm_ctrl;

   localparam int N    = 4;
   localparam int SW   = 2;
   localparam int SNZ  = 5;
   localparam int RING = 60;
   localparam int MAXS = 3;
`ifdef MULTI_ALARM_SNOOZE_LIMIT_EN
   localparam bit LIMIT = 1'b1;
`else
   localparam bit LIMIT = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          one_second, one_minute;
   logic [3:0]    cur_mh, cur_lh, cur_mm, cur_lm;
   logic [N-1:0]  alarm_en;
   logic          stop_button, snooze_button;
   logic          alarm_sound, snoozing;
   logic [SW-1:0] active_slot;

   multi_alarm_ctrl_if #(.SLOT_W(SW)) bus ();

   multi_alarm_ctrl #(
      .NUM_ALARMS (N), .SLOT_W (SW), .SNOOZE_MIN (SNZ),
      .RING_SEC (RING), .MAX_SNOOZE (MAXS)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .one_second          (one_second),
      .one_minute          (one_minute),
      .current_time_ms_hr  (cur_mh),
      .current_time_ls_hr  (cur_lh),
      .current_time_ms_min (cur_mm),
      .current_time_ls_min (cur_lm),
      .alarm_en            (alarm_en),
      .stop_button         (stop_button),
      .snooze_button       (snooze_button),
      .bus                 (bus),
      .alarm_sound         (alarm_sound),
      .active_slot         (active_slot),
      .snoozing            (snoozing)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int           m_slot [N];      // minutes of day
   logic [N-1:0] m_prev, m_pend;
   int           m_mode;          // 0 quiet, 1 ringing, 2 snoozed
   int           m_sec, m_min, m_used, m_act;
   bit           m_err;

   function automatic int tmin(input int a, input int b, input int c, input int d);
      return (a * 10 + b) * 60 + c * 10 + d;
   endfunction

   function automatic bit legal(input int a, input int b, input int c, input int d, input int s);
      return (a <= 2) && !(a == 2 && b > 3) && (c <= 5) && (d <= 9) && (s < N);
   endfunction

   task automatic model_update();
      logic [N-1:0] m;
      int tm;
      tm = tmin(cur_mh, cur_lh, cur_mm, cur_lm);
      if (reset) begin
         for (int i = 0; i < N; i++) m_slot[i] = 0;
         m_prev = '0; m_pend = '0; m_mode = 0;
         m_sec = 0; m_min = 0; m_used = 0; m_act = 0; m_err = 0;
         return;
      end
      for (int i = 0; i < N; i++) m[i] = alarm_en[i] && (m_slot[i] == tm);
      if (m_mode == 0) begin
         if (m_pend != 0) begin
            for (int i = N - 1; i >= 0; i--) if (m_pend[i]) m_act = i;
            m_mode = 1; m_sec = RING; m_used = 0;
         end
      end else if (stop_button || !alarm_en[m_act]) begin
         m_mode = 0;
      end else if (m_mode == 1) begin
         if (snooze_button) begin
            if (LIMIT && m_used >= MAXS) m_mode = 0;
            else begin m_mode = 2; m_min = SNZ; m_used++; end
         end else if (one_second) begin
            m_sec--;
            if (m_sec == 0) m_mode = 0;
         end
      end else if (one_minute) begin
         m_min--;
         if (m_min == 0) begin m_mode = 1; m_sec = RING; end
      end
      m_pend = m & ~m_prev;
      m_prev = m;
      m_err = 0;
      if (bus.load_new_a) begin
         if (legal(bus.new_alarm_ms_hr, bus.new_alarm_ls_hr, bus.new_alarm_ms_min,
                   bus.new_alarm_ls_min, bus.load_slot))
            m_slot[bus.load_slot] = tmin(bus.new_alarm_ms_hr, bus.new_alarm_ls_hr,
                                         bus.new_alarm_ms_min, bus.new_alarm_ls_min);
         else
            m_err = 1;
      end
   endtask

   // One clock: advance the model on the current inputs, sample #1 after the edge.
   task automatic step();
      model_update();
      @(posedge clock);
      #1;
      check("sound", alarm_sound, m_mode == 1);
      check("snoozing", snoozing, m_mode == 2);
      check("active_slot", active_slot, m_act);
      check("load_error", bus.load_error, m_err);
      check("disp", tmin(bus.alarm_time_ms_hr, bus.alarm_time_ls_hr,
                         bus.alarm_time_ms_min, bus.alarm_time_ls_min),
            m_slot[bus.disp_slot]);
      one_second = 0; one_minute = 0; stop_button = 0; snooze_button = 0;
      bus.load_new_a = 0;
   endtask

   task automatic set_time(input int a, input int b, input int c, input int d);
      cur_mh = 4'(a); cur_lh = 4'(b); cur_mm = 4'(c); cur_lm = 4'(d);
   endtask

   task automatic load(input int s, input int a, input int b, input int c, input int d);
      bus.load_slot = SW'(s);
      bus.new_alarm_ms_hr = 4'(a); bus.new_alarm_ls_hr = 4'(b);
      bus.new_alarm_ms_min = 4'(c); bus.new_alarm_ls_min = 4'(d);
      bus.load_new_a = 1;
      step();
   endtask

   // Move time away and back to a:b:c:d, then wait the two-clock latency.
   task automatic fire(input int a, input int b, input int c, input int d);
      set_time(2, 3, 5, 9); step(); step();
      set_time(a, b, c, d); step(); step();
   endtask

   task automatic pulse_minutes(input int n);
      for (int i = 0; i < n; i++) begin one_minute = 1; step(); step(); end
   endtask

   initial begin
      reset = 1; one_second = 0; one_minute = 0; stop_button = 0; snooze_button = 0;
      alarm_en = '0; set_time(0, 0, 0, 1);
      bus.load_new_a = 0; bus.load_slot = '0; bus.disp_slot = '0;
      bus.new_alarm_ms_hr = 0; bus.new_alarm_ls_hr = 0;
      bus.new_alarm_ms_min = 0; bus.new_alarm_ls_min = 0;
      step(); step();
      check("rst_sound", alarm_sound, 0);
      check("rst_active", active_slot, 0);
      reset = 0; step();

      // Slot 1 = 07:30, armed; 07:29 -> 07:30 rings two clocks later.
      load(1, 0, 7, 3, 0);
      alarm_en = 4'b0010; bus.disp_slot = 1;
      set_time(0, 7, 2, 9); step(); step();
      set_time(0, 7, 3, 0); step();
      check("lat1_sound", alarm_sound, 0);
      step();
      check("lat2_sound", alarm_sound, 1);
      check("lat2_slot", active_slot, 1);

      // Illegal 24:00 into slot 0 while ringing: error pulse, slot unchanged.
      bus.disp_slot = 0;
      load(0, 2, 4, 0, 0);
      check("err_pulse", bus.load_error, 1);
      step();
      check("err_gone", bus.load_error, 0);
      check("err_keeps_ring", alarm_sound, 1);

      // Snooze, re-ring after 5 minutes with a full 60 s ring.
      snooze_button = 1; step();
      check("snz_sound", alarm_sound, 0);
      check("snz_flag", snoozing, 1);
      pulse_minutes(4);
      check("snz_4min", snoozing, 1);
      pulse_minutes(1);
      check("rering", alarm_sound, 1);
      for (int i = 0; i < RING - 1; i++) begin one_second = 1; step(); end
      check("ring_59s", alarm_sound, 1);
      one_second = 1; step();
      check("ring_60s", alarm_sound, 0);

      // Slots 0 and 2 at 06:00: lowest wins; stop+snooze together -> idle.
      load(0, 0, 6, 0, 0); load(2, 0, 6, 0, 0);
      alarm_en = 4'b0101;
      fire(0, 6, 0, 0);
      check("prio_slot", active_slot, 0);
      check("prio_sound", alarm_sound, 1);
      stop_button = 1; snooze_button = 1; step();
      check("stop_wins", alarm_sound | snoozing, 0);

      // Snooze limit: three full snoozes, then a fourth press.
      fire(0, 6, 0, 0);
      for (int k = 0; k < MAXS; k++) begin
         snooze_button = 1; step();
         pulse_minutes(SNZ);
      end
      check("pre4_sound", alarm_sound, 1);
      snooze_button = 1; step();
      check("snz4_flag", snoozing, LIMIT ? 0 : 1);
      stop_button = 1; step();

      // Disarm while ringing.
      fire(0, 6, 0, 0);
      alarm_en = 4'b0100; step();
      check("disarm", alarm_sound, 0);

      // Reset mid-ring clears slots.
      alarm_en = 4'b0001;
      fire(0, 6, 0, 0);
      reset = 1; step();
      check("rst_mid_sound", alarm_sound, 0);
      check("rst_mid_slot", tmin(bus.alarm_time_ms_hr, bus.alarm_time_ls_hr,
                                 bus.alarm_time_ms_min, bus.alarm_time_ls_min), 0);
      reset = 0; step();

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 1) == 0) begin
               int s;
               s = $urandom_range(0, N - 1);
               set_time(m_slot[s] / 600, (m_slot[s] / 60) % 10,
                        (m_slot[s] % 60) / 10, m_slot[s] % 10);
            end else
               set_time($urandom_range(0, 2), $urandom_range(0, 3),
                        $urandom_range(0, 5), $urandom_range(0, 9));
         end
         one_second    = ($urandom_range(0, 3) == 0);
         one_minute    = ($urandom_range(0, 7) == 0);
         stop_button   = ($urandom_range(0, 59) == 0);
         snooze_button = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 99) == 0) alarm_en = N'($urandom);
         if ($urandom_range(0, 29) == 0) begin
            bus.load_new_a = 1;
            bus.load_slot = SW'($urandom_range(0, N - 1));
            bus.new_alarm_ms_hr = 4'($urandom_range(0, 3));
            bus.new_alarm_ls_hr = 4'($urandom_range(0, 9));
            bus.new_alarm_ms_min = 4'($urandom_range(0, 6));
            bus.new_alarm_ls_min = 4'($urandom_range(0, 9));
         end
         bus.disp_slot = SW'($urandom_range(0, N - 1));
         reset = ($urandom_range(0, 999) == 0);
         step();
      end
      reset = 0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
